// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with round-robin replacement,
// word-by-word line refill, full-cache flush and redirect clear.
module icache_assoc #(
   parameter int SETS       = 64,
   parameter int WAYS       = 2,
   parameter int LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        in_from_insFetcher_valid,
   input  logic [31:0] in_from_insFetcher_addr,
   output logic        out_to_insFetcher_ready,
   output logic        out_to_insFetcher_valid,
   output logic [31:0] out_to_insFetcher_ins,
   output logic [31:0] out_to_insFetcher_addr,
   input  logic        in_from_rob_clear,
   input  logic        in_flush,
   output logic        out_to_memCtrl_valid,
   output logic [31:0] out_to_memCtrl_addr,
   input  logic        in_from_memCtrl_valid,
   input  logic [31:0] in_from_memCtrl_ins
);

   localparam int WB   = $clog2(LINE_WORDS);
   localparam int OFF  = WB + 2;
   localparam int IB   = $clog2(SETS);
   localparam int TAGW = 32 - OFF - IB;
   localparam int KW   = (WB > 0) ? WB : 1;
   localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REFILL  = 2'd1;
   localparam logic [1:0] S_RESPOND = 2'd2;
   localparam logic [1:0] S_DRAIN   = 2'd3;

   logic [1:0]      state;
   logic [31:0]     pc_q;
   logic [KW-1:0]   k;
   logic [VW-1:0]   vic_q;
   logic            cancel_q;
   logic [31:0]     fill_word;
   logic            resp_q;
   logic [31:0]     ins_q;
   logic [31:0]     addr_q;

   logic [TAGW-1:0] tag_mem  [WAYS][SETS];
   logic [31:0]     data_mem [WAYS][SETS][LINE_WORDS];
   logic [SETS-1:0] valid_q  [WAYS];
   logic [VW-1:0]   rr_q     [SETS];

   logic [IB-1:0]   req_idx;
   logic [TAGW-1:0] req_tag;
   logic [KW-1:0]   req_sel;
   logic [IB-1:0]   fill_idx;
   logic [TAGW-1:0] fill_tag;
   logic [KW-1:0]   fill_sel;
   logic            hit;
   logic [31:0]     hit_word;
   logic            accept;
   logic            last_word;
   logic            mem_fire;
   logic            install;

   assign req_idx  = IB'(in_from_insFetcher_addr >> OFF);
   assign req_tag  = TAGW'(in_from_insFetcher_addr >> (OFF + IB));
   assign req_sel  = KW'((in_from_insFetcher_addr >> 2) & (LINE_WORDS - 1));
   assign fill_idx = IB'(pc_q >> OFF);
   assign fill_tag = TAGW'(pc_q >> (OFF + IB));
   assign fill_sel = KW'((pc_q >> 2) & (LINE_WORDS - 1));

   // A clear or flush in the same cycle as a request means the request is refused.
   assign out_to_insFetcher_ready = rdy && !rst && (state == S_IDLE) &&
                                    !in_from_rob_clear && !in_flush;
   assign accept    = in_from_insFetcher_valid && out_to_insFetcher_ready;
   assign last_word = (k == KW'(LINE_WORDS - 1));
   assign mem_fire  = rdy && (state == S_REFILL) && in_from_memCtrl_valid;
   assign install   = mem_fire && last_word && !in_flush;

   // The registered response is masked by a redirect/flush arriving in its own cycle.
   assign out_to_insFetcher_valid = resp_q && !in_from_rob_clear && !in_flush;
   assign out_to_insFetcher_ins   = ins_q;
   assign out_to_insFetcher_addr  = addr_q;

   // The request stays asserted through DRAIN so the outstanding word is still served.
   assign out_to_memCtrl_valid = (state == S_REFILL) || (state == S_DRAIN);
   assign out_to_memCtrl_addr  = out_to_memCtrl_valid ?
                                 ((pc_q & ~32'(LINE_WORDS * 4 - 1)) | (32'(k) << 2)) : '0;

   // Tag compare across all ways for the incoming fetch address.
   always_comb begin
      hit      = 1'b0;
      hit_word = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!hit && valid_q[VW'(w)][req_idx] && (tag_mem[VW'(w)][req_idx] == req_tag)) begin
            hit      = 1'b1;
            hit_word = data_mem[VW'(w)][req_idx][req_sel];
         end
      end
   end

   // Tag and data arrays: written by refill only, no reset.
   always_ff @(posedge clk) begin
      if (mem_fire)
         data_mem[vic_q][fill_idx][k] <= in_from_memCtrl_ins;
      if (install)
         tag_mem[vic_q][fill_idx] <= fill_tag;
   end

   // Miss FSM, response registers, valid bits and victim pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         pc_q      <= '0;
         k         <= '0;
         vic_q     <= '0;
         cancel_q  <= 1'b0;
         fill_word <= '0;
         resp_q    <= 1'b0;
         ins_q     <= '0;
         addr_q    <= '0;
         for (int unsigned w = 0; w < WAYS; w++)
            valid_q[VW'(w)] <= '0;
         for (int unsigned s = 0; s < SETS; s++)
            rr_q[IB'(s)] <= '0;
      end else if (rdy) begin
         resp_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  pc_q <= in_from_insFetcher_addr;
                  if (hit) begin
                     resp_q <= 1'b1;
                     ins_q  <= hit_word;
                     addr_q <= in_from_insFetcher_addr;
                  end else begin
                     state    <= S_REFILL;
                     k        <= '0;
                     cancel_q <= 1'b0;
                     vic_q    <= rr_q[req_idx];
                  end
               end
            end
            S_REFILL: begin
               if (in_from_rob_clear)
                  cancel_q <= 1'b1;
               if (mem_fire) begin
                  if (k == fill_sel)
                     fill_word <= in_from_memCtrl_ins;
                  if (last_word) begin
                     if (in_flush) begin
                        state <= S_IDLE;
                     end else begin
                        valid_q[vic_q][fill_idx] <= 1'b1;
                        if (WAYS > 1)
                           rr_q[fill_idx] <= rr_q[fill_idx] + 1'b1;
                        if (cancel_q || in_from_rob_clear) begin
                           state <= S_IDLE;
                        end else begin
                           state  <= S_RESPOND;
                           resp_q <= 1'b1;
                           ins_q  <= (k == fill_sel) ? in_from_memCtrl_ins : fill_word;
                           addr_q <= pc_q;
                        end
                     end
                  end else begin
                     k <= k + 1'b1;
                     if (in_flush)
                        state <= S_IDLE;
                  end
               end else if (in_flush) begin
                  state <= S_DRAIN;
               end
            end
            S_RESPOND: state <= S_IDLE;
            S_DRAIN: begin
               if (in_from_memCtrl_valid)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
         if (in_flush) begin
            for (int unsigned w = 0; w < WAYS; w++)
               valid_q[VW'(w)] <= '0;
            for (int unsigned s = 0; s < SETS; s++)
               rr_q[IB'(s)] <= '0;
         end
      end
   end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache between the instruction fetcher and the memory controller; the successor to the direct-mapped single-word cache. It supports configurable sets, ways and line length, and refills a whole line word-by-word through a miss FSM. It also provides valid/ready handshaking on the fetch side, round-robin replacement, a full-cache flush, and a redirect clear that cancels the pending fetch response.

## Interface
- SETS, 64, number of sets (power of 2, ≥2)
- WAYS, 2, associativity (power of 2, ≥1)
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥1)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; when low all state holds
- in_from_insFetcher_valid  in  1  fetch request
- in_from_insFetcher_addr  in  32  fetch PC (bits 1:0 ignored)
- out_to_insFetcher_ready  out  1  cache can accept a request (state IDLE and rdy)
- out_to_insFetcher_valid  out  1  one-cycle response pulse
- out_to_insFetcher_ins  out  32  instruction for the accepted PC
- out_to_insFetcher_addr  out  32  PC the response belongs to
- in_from_rob_clear  in  1  redirect: drop pending response
- in_flush  in  1  invalidate all lines
- out_to_memCtrl_valid  out  1  word read request, held until served
- out_to_memCtrl_addr  out  32  word-aligned read address
- in_from_memCtrl_valid  in  1  read data valid (one cycle per word)
- in_from_memCtrl_ins  in  32  read data

## Operation
- Address split: OFF = log2(LINE_WORDS)+2.
  - Word select = addr[OFF-1:2].
  - Index = addr[OFF+log2(SETS)-1:OFF].
  - Tag = remaining upper bits.
- Valid bits are flops, to allow single-cycle flush. Tag and data arrays have no reset.
- Each set has a log2(WAYS)-bit round-robin victim pointer, reset to 0, incremented modulo WAYS on each completed refill of that set. An invalid way is not preferred; the pointer alone selects the victim.
- FSM states: IDLE, REFILL, RESPOND, DRAIN.
- IDLE: on valid&&ready, latch the PC.
  - Hit (any way valid with matching tag): register the word. Next cycle drive out_to_insFetcher_valid=1 with ins/addr, and stay in IDLE.
  - Miss: set word counter k=0 and go to REFILL.
- REFILL:
  - out_to_memCtrl_valid=1, addr = {line base, k, 2'b00}.
  - Each in_from_memCtrl_valid writes word k into the victim way, then k++.
  - After word LINE_WORDS-1: write tag, set valid, advance the victim pointer, go to RESPOND.
- RESPOND: output the latched PC's word (taken from refill data), valid=1 for one cycle, go to IDLE.
- in_from_rob_clear:
  - In IDLE it suppresses a hit response due next cycle.
  - In REFILL the refill completes and the line is installed, but RESPOND is skipped: REFILL goes directly to IDLE.
  - In RESPOND the response is suppressed.
  - A clear asserted together with a new request in IDLE means the request is not accepted; ready is forced low that cycle.
- in_flush:
  - Clears all valid bits and victim pointers at the next edge.
  - In REFILL with a word outstanding, go to DRAIN. DRAIN waits for the outstanding in_from_memCtrl_valid, discards the data, then goes to IDLE.
  - Flush implies clear: no response is produced.
  - A flush coinciding with the final refill word still invalidates, and that line is not installed.
- rdy low: no state, counter, array or output change. memCtrl responses are not expected while rdy is low.

## Timing
- Reset values:
  - ready=0 during reset, 1 in the first rdy cycle after.
  - All other outputs 0: valid, ins, addr, memCtrl valid and addr.
  - State IDLE, valid bits 0.
- Hit latency is 1 cycle (request edge N, response during N+1). Throughput is one hit per cycle.
- Miss latency = 1 + sum of memory latencies + 1. memCtrl valid asserts the cycle after the miss is sampled, and the address advances in the cycle after each served word.
- out_to_memCtrl_valid drops in the cycle after the last word.
- Response pulses exactly one cycle, never on a cancelled fetch.

## Test plan
- Reset, then cold miss at 0x100 (LINE_WORDS=4), memory returning 0xA0..0xA3 with 0–3 cycle gaps:
  - Required: memCtrl addrs 0x100, 0x104, 0x108, 0x10C, then response ins=0xA0, addr=0x100.
  - Then fetches 0x104/0x108/0x10C hit on consecutive cycles with 0xA1..0xA3 and no memCtrl activity.
- With SETS=64, WAYS=2, line bytes=16, fill 0x000, 0x400 and 0x800, all in set 0:
  - Third fill evicts 0x000 and a refetch of 0x000 misses.
  - 0x400 and 0x800 hit.
- in_flush on the second word of a refill:
  - Required: DRAIN consumes one more response, no response is produced.
  - Refetch of the same PC misses.
- in_from_rob_clear during REFILL:
  - Required: the line completes and no response is produced.
  - A following fetch of the same PC hits with 1-cycle latency.
- rdy low for 5 cycles mid-REFILL:
  - Required: memCtrl addr, state and outputs are frozen.
  - After release the refill resumes at the same word.
- Hit request with simultaneous clear:
  - Required: ready=0 that cycle, no response, no state change.
